// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the registered output bundle
// used by the sync generator and the display switch.
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_DIV       = 4;
  localparam int VGA_CNT_W     = 10;

  // Both syncs are active-low for this mode.
  localparam logic VGA_H_SYNC_POL = 1'b0;
  localparam logic VGA_V_SYNC_POL = 1'b0;

  typedef struct packed {
    logic                 h_sync;
    logic                 v_sync;
    logic                 de;
    logic [VGA_CNT_W-1:0] x;
    logic [VGA_CNT_W-1:0] y;
    logic                 pclk_tick;
    logic                 line_start;
    logic                 frame_start;
  } sync_out_t;

  function automatic logic in_window(input logic [VGA_CNT_W-1:0] cnt,
                                     input logic [VGA_CNT_W-1:0] lo,
                                     input logic [VGA_CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate divider: div counts 0..DIV-1 while enabled; tick marks the
// last system clock of each pixel.
module pixel_tick_gen
  import vga_pkg::*;
#(
  parameter int DIV = VGA_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int              DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters plus fully registered
// sync, display-enable, coordinate and start-pulse outputs (1-clk latency).
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int DIV       = VGA_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 DE,
  output logic [VGA_CNT_W-1:0] x_pixel,
  output logic [VGA_CNT_W-1:0] y_pixel,
  output logic                 pclk_tick,
  output logic                 line_start,
  output logic                 frame_start
);

  localparam int CW      = VGA_CNT_W;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_END    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_END    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic          tick;
  logic          at_zero;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  sync_out_t     out_q;

  pixel_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .tick  (tick)
  );

  // at_zero mirrors div == 0: the divider only returns to 0 after a tick edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      at_zero <= 1'b1;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (en) begin
      at_zero <= tick;
      if (tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
        end else begin
          h_cnt <= h_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q.h_sync      <= ~VGA_H_SYNC_POL;
      out_q.v_sync      <= ~VGA_V_SYNC_POL;
      out_q.de          <= 1'b0;
      out_q.x           <= '0;
      out_q.y           <= '0;
      out_q.pclk_tick   <= 1'b0;
      out_q.line_start  <= 1'b0;
      out_q.frame_start <= 1'b0;
    end else if (en) begin
      out_q.h_sync      <= in_window(h_cnt, H_SYNC_FIRST, H_SYNC_LAST) ?
                           VGA_H_SYNC_POL : ~VGA_H_SYNC_POL;
      out_q.v_sync      <= in_window(v_cnt, V_SYNC_FIRST, V_SYNC_LAST) ?
                           VGA_V_SYNC_POL : ~VGA_V_SYNC_POL;
      out_q.de          <= (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
      out_q.x           <= h_cnt;
      out_q.y           <= v_cnt;
      out_q.pclk_tick   <= at_zero;
      out_q.line_start  <= at_zero && (h_cnt == '0);
      out_q.frame_start <= at_zero && (h_cnt == '0) && (v_cnt == '0);
    end else begin
      // Frozen: levels hold, pulses never stretch across the pause.
      out_q.pclk_tick   <= 1'b0;
      out_q.line_start  <= 1'b0;
      out_q.frame_start <= 1'b0;
    end
  end

  assign h_sync      = out_q.h_sync;
  assign v_sync      = out_q.v_sync;
  assign DE          = out_q.de;
  assign x_pixel     = out_q.x;
  assign y_pixel     = out_q.y;
  assign pclk_tick   = out_q.pclk_tick;
  assign line_start  = out_q.line_start;
  assign frame_start = out_q.frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance for line timing and a shrunk
// instance for frame wrap, both scored against an arithmetic raster model.
module tb_vga_sync_gen;

  localparam int W = 26;
  localparam logic [W-1:0] RESET_WORD = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 3'b000};

  // Shrunk timing: 13 pixels x 8 lines x 2 clk = 208 clk per frame.
  localparam int S_HV = 6, S_HFP = 2, S_HS = 3, S_HBP = 2;
  localparam int S_VV = 4, S_VFP = 1, S_VS = 2, S_VBP = 1, S_DIV = 2;
  localparam int S_FRAME = (S_HV + S_HFP + S_HS + S_HBP) * (S_VV + S_VFP + S_VS + S_VBP) * S_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;

  logic       h_sync_m, v_sync_m, de_m, pclk_m, ls_m, fs_m;
  logic [9:0] x_m, y_m;
  logic       h_sync_s, v_sync_s, de_s, pclk_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;

  vga_sync_gen dut_m (
    .clk(clk), .reset(reset), .en(en),
    .h_sync(h_sync_m), .v_sync(v_sync_m), .DE(de_m),
    .x_pixel(x_m), .y_pixel(y_m),
    .pclk_tick(pclk_m), .line_start(ls_m), .frame_start(fs_m)
  );

  vga_sync_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP), .DIV(S_DIV)
  ) dut_s (
    .clk(clk), .reset(reset), .en(en),
    .h_sync(h_sync_s), .v_sync(v_sync_s), .DE(de_s),
    .x_pixel(x_s), .y_pixel(y_s),
    .pclk_tick(pclk_s), .line_start(ls_s), .frame_start(fs_s)
  );

  logic [W-1:0] obs_m, obs_s;
  assign obs_m = {h_sync_m, v_sync_m, de_m, x_m, y_m, pclk_m, ls_m, fs_m};
  assign obs_s = {h_sync_s, v_sync_s, de_s, x_s, y_s, pclk_s, ls_s, fs_s};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_s_q[$];
  logic [W-1:0] prev_m, prev_s;
  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int t_m = 0;
  int t_s = 0;

  // Expected outputs after t enabled edges, computed from absolute time.
  function automatic logic [W-1:0] model(input int t, input int dv,
                                         input int hv, input int hfp, input int hs, input int hbp,
                                         input int vv, input int vfp, input int vs, input int vbp);
    int   ht, vt, d, pix, h, v;
    logic hsn, vsn, de, pt;
    ht  = hv + hfp + hs + hbp;
    vt  = vv + vfp + vs + vbp;
    d   = t % dv;
    pix = t / dv;
    h   = pix % ht;
    v   = (pix / ht) % vt;
    hsn = !((h >= hv + hfp) && (h < hv + hfp + hs));
    vsn = !((v >= vv + vfp) && (v < vv + vfp + vs));
    de  = (h < hv) && (v < vv);
    pt  = (d == 0);
    return {hsn, vsn, de, h[9:0], v[9:0], pt, pt && (h == 0), pt && (h == 0) && (v == 0)};
  endfunction

  task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en_v);
    logic [W-1:0] em, es;
    en = en_v;
    if (en_v) begin
      em = model(t_m, 4, 640, 16, 96, 48, 480, 10, 2, 33);
      es = model(t_s, S_DIV, S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP);
      t_m++;
      t_s++;
    end else begin
      em = prev_m & ~W'(7);
      es = prev_s & ~W'(7);
    end
    prev_m = em;
    prev_s = es;
    exp_q.push_back(em);
    exp_s_q.push_back(es);
    @(posedge clk);
    #1;
    edge_n++;
    check_word($sformatf("main_e%0d", edge_n), obs_m, exp_q.pop_front());
    check_word($sformatf("small_e%0d", edge_n), obs_s, exp_s_q.pop_front());
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    #1;
    check_word("reset_now_main", obs_m, RESET_WORD);
    check_word("reset_now_small", obs_s, RESET_WORD);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check_word("reset_hold_main", obs_m, RESET_WORD);
      check_word("reset_hold_small", obs_s, RESET_WORD);
    end
    reset  = 1'b1;
    t_m    = 0;
    t_s    = 0;
    edge_n = 0;
    prev_m = RESET_WORD;
    prev_s = RESET_WORD;
    exp_q.delete();
    exp_s_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int   hs_first, hs_last, de_fall, ls_cnt, ls1, ls2;
    int   fs_cnt, fs2, vs_low, de_pix, e300, en_edges;
    logic de_prev, found, pulse_seen;

    reset = 1'b1;
    en    = 1'b0;
    #2;
    do_reset(3);

    // One full line plus change on both instances.
    hs_first = -1; hs_last = -1; de_fall = -1; ls_cnt = 0; ls1 = -1; ls2 = -1;
    fs_cnt = 0; fs2 = -1; vs_low = 0; de_pix = 0; de_prev = 1'b0;
    for (int i = 0; i < 3210; i++) begin
      step(1'b1);
      if (edge_n == 1)
        check_word("edge1_de_fs_x_y", W'({de_m, fs_m, x_m, y_m}), W'({1'b1, 1'b1, 20'd0}));
      if (edge_n == 5)
        check_word("edge5_pclk_x", W'({pclk_m, x_m}), W'({1'b1, 10'd1}));
      if (edge_n <= 3200 && !h_sync_m) begin
        if (hs_first < 0) hs_first = edge_n;
        hs_last = edge_n;
      end
      if (de_prev && !de_m && de_fall < 0) de_fall = edge_n;
      de_prev = de_m;
      if (ls_m) begin
        ls_cnt++;
        if (ls1 < 0) ls1 = edge_n;
        else if (ls2 < 0) ls2 = edge_n;
      end
      if (edge_n <= S_FRAME) begin
        if (fs_s) fs_cnt++;
        if (!v_sync_s) vs_low++;
        if (de_s && pclk_s) de_pix++;
      end
      if (fs_s && edge_n > 1 && fs2 < 0) fs2 = edge_n;
      if (edge_n == S_FRAME + 1)
        check_word("wrap_corner_small", W'({x_s, y_s, ls_s, fs_s}), W'({20'd0, 2'b11}));
    end
    check_int("hsync_first_low", hs_first, 2625);
    check_int("hsync_last_low", hs_last, 3008);
    check_int("de_fall_edge", de_fall, 2561);
    check_int("line_start_count", ls_cnt, 2);
    check_int("line_start_1st", ls1, 1);
    check_int("line_start_2nd", ls2, 3201);
    check_int("small_fs_per_frame", fs_cnt, 1);
    check_int("small_fs_2nd", fs2, S_FRAME + 1);
    check_int("small_vsync_low_clk", vs_low, S_VS * (S_HV + S_HFP + S_HS + S_HBP) * S_DIV);
    check_int("small_de_pixels", de_pix, S_HV * S_VV);

    // Freeze mid-line at x=300 and confirm the divider phase survives.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step(1'b1);
      if (x_m == 10'd300) found = 1'b1;
    end
    check_int("reach_x300", int'(found), 1);
    e300 = 0;
    repeat (2) begin
      step(1'b1);
      e300++;
    end
    pulse_seen = 1'b0;
    repeat (37) begin
      step(1'b0);
      pulse_seen = pulse_seen | pclk_m | ls_m | fs_m | pclk_s | ls_s | fs_s;
    end
    check_int("freeze_pulses", int'(pulse_seen), 0);
    check_int("freeze_x", int'(x_m), 300);
    en_edges = e300;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b1);
      en_edges++;
      if (x_m == 10'd301) found = 1'b1;
    end
    check_int("reach_x301", int'(found), 1);
    check_int("x300_to_x301_enabled_edges", en_edges, 4);

    // Mid-frame reset, then a clean restart and full shrunk frame.
    found = 1'b0;
    for (int i = 0; i < 2 * S_FRAME && !found; i++) begin
      step(1'b1);
      if (y_s == 10'd3 && x_s == 10'd5) found = 1'b1;
    end
    check_int("reach_small_y3_x5", int'(found), 1);
    do_reset(3);
    fs_cnt = 0; fs2 = -1; vs_low = 0;
    for (int i = 0; i < S_FRAME + 1; i++) begin
      step(1'b1);
      if (edge_n == 1) begin
        check_word("restart_main_pulses", W'({de_m, pclk_m, ls_m, fs_m}), W'(4'b1111));
        check_word("restart_small_pulses", W'({de_s, pclk_s, ls_s, fs_s}), W'(4'b1111));
      end
      if (edge_n <= S_FRAME && !v_sync_s) vs_low++;
      if (fs_s) begin
        fs_cnt++;
        if (edge_n > 1) fs2 = edge_n;
      end
    end
    check_int("restart_small_fs_count", fs_cnt, 2);
    check_int("restart_small_fs_2nd", fs2, S_FRAME + 1);
    check_int("restart_small_vsync_low_clk", vs_low, S_VS * (S_HV + S_HFP + S_HS + S_HBP) * S_DIV);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
